// File: rtl/systolic_pkg.sv
// Shared definitions for the systolic array operand path: default array
// geometry, the feeder state encoding and a lane-slicing helper.
package systolic_pkg;

  localparam int ARRAY_N = 4;
  localparam int DATA_W  = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    FLUSH  = 2'd2
  } feeder_state_e;

  // Lowest bit position of lane 'lane' in a bus of 'width'-bit lanes.
  function automatic int lane_lsb(input int lane, input int width);
    return lane * width;
  endfunction

endpackage

// File: rtl/skew_delay_line.sv
// Fixed-depth shift register carrying one operand lane plus its valid flag.
// Data entering without valid is forced to zero, so every slot that is not
// a real element reaches the array edge as a zero operand.
module skew_delay_line #(
  parameter int DEPTH = 1,
  parameter int W     = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  output logic [W-1:0] out_data
);

  logic [W-1:0]     data_r [DEPTH];
  logic [DEPTH-1:0] valid_r;

  // Shift the lane by one stage every cycle; the head takes new data or a zero bubble.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int s = 0; s < DEPTH; s++) begin
        data_r[s] <= '0;
      end
      valid_r <= '0;
    end else begin
      data_r[0]  <= in_valid ? in_data : '0;
      valid_r[0] <= in_valid;
      for (int s = 1; s < DEPTH; s++) begin
        data_r[s]  <= data_r[s-1];
        valid_r[s] <= valid_r[s-1];
      end
    end
  end

  assign out_data  = data_r[DEPTH-1];
  assign out_valid = valid_r[DEPTH-1];

endmodule

// File: rtl/systolic_operand_feeder.sv
// Operand feeder for one edge (west or north) of an N x N systolic array.
// Accepts one N-lane vector per handshake, delays lane i by i extra cycles
// so matching A/B elements meet in each PE, then drains the skew lines and
// pulses done when the last element leaves the deepest lane.
module systolic_operand_feeder
  import systolic_pkg::*;
#(
  parameter int N  = ARRAY_N,
  parameter int W  = DATA_W,
  parameter int KW = 16
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [KW-1:0]  k_len,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [N*W-1:0] in_data,
  output logic [N*W-1:0] edge_data,
  output logic [N-1:0]   edge_lane_valid,
  output logic           busy,
  output logic           done
);

  localparam int FCW = (N > 1) ? $clog2(N) : 1;

  feeder_state_e  state_r, state_s;
  logic [KW-1:0]  count_r, count_s;
  logic [KW-1:0]  k_len_r, k_len_s;
  logic [FCW-1:0] flush_cnt_r, flush_cnt_s;
  logic           done_r, done_s;
  logic           accept_s;

  // Ready depends on state alone so the partner feeder sees the same handshake.
  assign in_ready = (state_r == STREAM);
  assign accept_s = in_valid & in_ready;
  assign busy     = (state_r != IDLE);
  assign done     = done_r;

  // Next-state, vector count and flush timing; done is computed one cycle ahead.
  always_comb begin
    state_s     = state_r;
    count_s     = count_r;
    k_len_s     = k_len_r;
    flush_cnt_s = flush_cnt_r;
    done_s      = 1'b0;
    case (state_r)
      IDLE: begin
        if (start) begin
          k_len_s = k_len;
          count_s = '0;
          if (k_len == '0) begin
            done_s = 1'b1;
          end else begin
            state_s = STREAM;
          end
        end else begin
          state_s = IDLE;
        end
      end
      STREAM: begin
        if (accept_s) begin
          count_s = count_r + KW'(1);
          if ((count_r + KW'(1)) == k_len_r) begin
            state_s     = FLUSH;
            flush_cnt_s = '0;
            // With a single lane the first flush cycle is already the last one.
            done_s      = (N == 1);
          end else begin
            state_s = STREAM;
          end
        end else begin
          state_s = STREAM;
        end
      end
      FLUSH: begin
        // The final flush cycle is the one in which the deepest lane shows its last element.
        if (flush_cnt_r == FCW'(N - 1)) begin
          state_s = IDLE;
        end else begin
          flush_cnt_s = flush_cnt_r + FCW'(1);
          done_s      = (flush_cnt_r == FCW'(N - 2));
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // Control state register; reset abandons any pass without a done pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= IDLE;
      count_r     <= '0;
      k_len_r     <= '0;
      flush_cnt_r <= '0;
      done_r      <= 1'b0;
    end else begin
      state_r     <= state_s;
      count_r     <= count_s;
      k_len_r     <= k_len_s;
      flush_cnt_r <= flush_cnt_s;
      done_r      <= done_s;
    end
  end

  // One skew line per lane, lane i being i+1 stages deep.
  for (genvar i = 0; i < N; i++) begin : g_lane
    skew_delay_line #(
      .DEPTH(i + 1),
      .W    (W)
    ) u_line (
      .clk      (clk),
      .rst      (rst),
      .in_valid (accept_s),
      .in_data  (in_data[lane_lsb(i, W) +: W]),
      .out_valid(edge_lane_valid[i]),
      .out_data (edge_data[lane_lsb(i, W) +: W])
    );
  end

endmodule

// File: tb/tb_systolic_operand_feeder.sv
// Self-checking bench for systolic_operand_feeder: a per-pass reference model
// built from accept history, directed scenarios and a lockstep A/B pair
// driving a behavioural 4x4 PE array.
module tb_systolic_operand_feeder;

  localparam int N  = 4;
  localparam int W  = 32;
  localparam int KW = 16;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           start = 1'b0;
  logic [KW-1:0]  k_len = '0;
  logic           in_valid = 1'b0;
  logic [N*W-1:0] in_data = '0;
  logic [N*W-1:0] in_data_b = '0;
  logic           in_ready, in_ready_b;
  logic [N*W-1:0] edge_data, edge_data_b;
  logic [N-1:0]   edge_lane_valid, edge_lane_valid_b;
  logic           busy, busy_b, done, done_b;

  int checks = 0;
  int failures = 0;

  logic [N*W-1:0] vec_q[$];
  int  valid_pct = 100;
  int  bubble_at = -1;
  bit  start_in_flush = 0;
  int  done_edge_seen = -1;

  systolic_operand_feeder #(.N(N), .W(W), .KW(KW)) dut (
    .clk(clk), .rst(rst), .start(start), .k_len(k_len),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .edge_data(edge_data), .edge_lane_valid(edge_lane_valid),
    .busy(busy), .done(done)
  );

  systolic_operand_feeder #(.N(N), .W(W), .KW(KW)) dut_b (
    .clk(clk), .rst(rst), .start(start), .k_len(k_len),
    .in_valid(in_valid), .in_ready(in_ready_b), .in_data(in_data_b),
    .edge_data(edge_data_b), .edge_lane_valid(edge_lane_valid_b),
    .busy(busy_b), .done(done_b)
  );

  always #5 clk = ~clk;

  // Behavioural PE array: a flows east, b flows south, c accumulates a*b.
  logic [W-1:0] pe_a[N][N];
  logic [W-1:0] pe_b[N][N];
  logic [W-1:0] pe_c[N][N];
  logic [W-1:0] west[N][N];
  logic [W-1:0] north[N][N];
  bit pe_clear = 0;

  for (genvar i = 0; i < N; i++) begin : g_r
    for (genvar j = 0; j < N; j++) begin : g_c
      if (j == 0) begin : g_w0
        assign west[i][j] = edge_data[i*W +: W];
      end else begin : g_wn
        assign west[i][j] = pe_a[i][j-1];
      end
      if (i == 0) begin : g_n0
        assign north[i][j] = edge_data_b[j*W +: W];
      end else begin : g_nn
        assign north[i][j] = pe_b[i-1][j];
      end
    end
  end

  always @(negedge clk) begin
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        if (pe_clear) begin
          pe_a[i][j] <= '0;
          pe_b[i][j] <= '0;
          pe_c[i][j] <= '0;
        end else begin
          pe_a[i][j] <= west[i][j];
          pe_b[i][j] <= north[i][j];
          pe_c[i][j] <= pe_c[i][j] + west[i][j] * north[i][j];
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // One full pass of length k checked every cycle against an accept-history model.
  task automatic run_pass(input int k);
    logic [N*W-1:0] hist_d[int];
    bit             hist_v[int];
    bit             m_stream;
    int             cnt, last, e, idx;
    bit             v;
    logic [N*W-1:0] d, exp_d;
    logic [N-1:0]   exp_v;
    bit             exp_done, exp_busy;
    @(negedge clk);
    start = 1'b1; k_len = KW'(k); in_valid = 1'b0;
    @(posedge clk); #1;
    m_stream = 1; cnt = 0; last = -1; done_edge_seen = -1;
    checks++;
    if (busy !== 1'b1 || in_ready !== 1'b1 || done !== 1'b0 || edge_lane_valid !== '0) begin
      failures++;
      $display("FAIL pass_start: busy=%b in_ready=%b done=%b lv=%b want 1 1 0 0000",
               busy, in_ready, done, edge_lane_valid);
    end
    for (e = 1; e < 2000; e++) begin
      @(negedge clk);
      start = (start_in_flush && !m_stream);
      k_len = start ? KW'(5) : KW'(k);
      v = ($urandom_range(99) < valid_pct) && (e != bubble_at);
      if (m_stream && v && vec_q.size() != 0) d = vec_q.pop_front();
      else for (int i = 0; i < N; i++) d[i*W +: W] = $urandom();
      in_valid = v; in_data = d;
      @(posedge clk);
      hist_v[e] = m_stream && v;
      hist_d[e] = d;
      if (hist_v[e]) begin
        cnt++;
        if (cnt == k) begin m_stream = 0; last = e; end
      end
      #1;
      for (int i = 0; i < N; i++) begin
        idx = e - i;
        if (idx >= 1 && hist_v[idx]) begin
          exp_v[i] = 1'b1; exp_d[i*W +: W] = hist_d[idx][i*W +: W];
        end else begin
          exp_v[i] = 1'b0; exp_d[i*W +: W] = '0;
        end
      end
      exp_done = (last >= 0 && e == last + N - 1);
      exp_busy = !(last >= 0 && e >= last + N);
      checks++;
      if (edge_data !== exp_d) begin
        failures++;
        $display("FAIL edge_data e=%0d: got %h want %h", e, edge_data, exp_d);
      end
      checks++;
      if (edge_lane_valid !== exp_v) begin
        failures++;
        $display("FAIL lane_valid e=%0d: got %b want %b", e, edge_lane_valid, exp_v);
      end
      checks++;
      if (done !== exp_done || busy !== exp_busy || in_ready !== m_stream) begin
        failures++;
        $display("FAIL ctrl e=%0d: done/busy/ready got %b%b%b want %b%b%b",
                 e, done, busy, in_ready, exp_done, exp_busy, m_stream);
      end
      if (done === 1'b1) done_edge_seen = e;
      if (last >= 0 && e == last + N) break;
    end
    start = 1'b0; in_valid = 1'b0;
    if (e >= 2000) begin
      checks++; failures++;
      $display("FAIL pass_timeout: k=%0d accepted=%0d", k, cnt);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (edge_data !== '0 || edge_lane_valid !== '0 || in_ready !== 1'b0 ||
        busy !== 1'b0 || done !== 1'b0) begin
      failures++;
      $display("FAIL reset_state: data=%h lv=%b rdy=%b busy=%b done=%b want all 0",
               edge_data, edge_lane_valid, in_ready, busy, done);
    end
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_basic();
    for (int v = 0; v < 3; v++) begin
      logic [N*W-1:0] x;
      for (int i = 0; i < N; i++) x[i*W +: W] = W'(v*N + i + 1);
      vec_q.push_back(x);
    end
    valid_pct = 100; bubble_at = -1;
    run_pass(3);
    checks++;
    if (done_edge_seen != 6) begin
      failures++;
      $display("FAIL basic_done_cycle: got %0d want 6", done_edge_seen);
    end
  endtask

  task automatic test_bubble();
    for (int v = 0; v < 3; v++) begin
      logic [N*W-1:0] x;
      for (int i = 0; i < N; i++) x[i*W +: W] = W'(v*N + i + 1);
      vec_q.push_back(x);
    end
    valid_pct = 100; bubble_at = 2;
    run_pass(3);
    bubble_at = -1;
    checks++;
    if (done_edge_seen != 7) begin
      failures++;
      $display("FAIL bubble_done_cycle: got %0d want 7", done_edge_seen);
    end
  endtask

  task automatic test_zero_len();
    bit bad;
    @(negedge clk); start = 1'b1; k_len = '0; in_valid = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (done !== 1'b1 || busy !== 1'b0 || in_ready !== 1'b0) begin
      failures++;
      $display("FAIL zero_len_done: done/busy/rdy got %b%b%b want 100", done, busy, in_ready);
    end
    @(negedge clk); start = 1'b0;
    bad = 0;
    repeat (5) begin
      @(posedge clk); #1;
      if (done !== 1'b0 || in_ready !== 1'b0 || edge_lane_valid !== '0) bad = 1;
    end
    in_valid = 1'b0;
    checks++;
    if (bad) begin
      failures++;
      $display("FAIL zero_len_after: got activity after pulse, want none");
    end
  endtask

  task automatic test_reset_mid_pass();
    bit saw_done;
    @(negedge clk); start = 1'b1; k_len = KW'(5);
    @(posedge clk);
    @(negedge clk); start = 1'b0; in_valid = 1'b1; in_data = {N{32'h0000_00AA}};
    @(posedge clk);
    @(negedge clk); in_data = {N{32'h0000_00BB}};
    @(posedge clk); #2;
    rst = 1'b1; #1;
    checks++;
    if (edge_data !== '0 || edge_lane_valid !== '0 || in_ready !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL mid_reset: data=%h lv=%b rdy=%b busy=%b want 0", edge_data,
               edge_lane_valid, in_ready, busy);
    end
    @(negedge clk); rst = 1'b0; in_valid = 1'b0;
    saw_done = 0;
    repeat (8) begin
      @(posedge clk); #1;
      if (done === 1'b1) saw_done = 1;
    end
    checks++;
    if (saw_done) begin
      failures++;
      $display("FAIL mid_reset_done: got done pulse, want none");
    end
    valid_pct = 100;
    run_pass(1);
  endtask

  task automatic test_start_while_busy();
    bit bad;
    valid_pct = 100; start_in_flush = 1;
    run_pass(2);
    start_in_flush = 0;
    bad = 0;
    repeat (6) begin
      @(posedge clk); #1;
      if (busy !== 1'b0 || done !== 1'b0 || in_ready !== 1'b0) bad = 1;
    end
    checks++;
    if (bad) begin
      failures++;
      $display("FAIL start_in_flush: got pass restarted, want ignored");
    end
    run_pass(2);
  endtask

  task automatic test_back_to_back();
    valid_pct = 60;
    for (int p = 0; p < 6; p++) run_pass(int'($urandom_range(8, 1)));
    valid_pct = 100;
    run_pass(5);
    run_pass(1);
  endtask

  task automatic test_lockstep();
    int done_a, done_bb;
    @(posedge clk); #1 pe_clear = 1;
    @(posedge clk); #1 pe_clear = 0;
    @(negedge clk); start = 1'b1; k_len = KW'(N);
    @(posedge clk);
    for (int k = 0; k < N; k++) begin
      @(negedge clk);
      start = 1'b0; in_valid = 1'b1;
      for (int i = 0; i < N; i++) begin
        in_data[i*W +: W]   = (i == k) ? W'(1) : W'(0);
        in_data_b[i*W +: W] = W'(k*N + i + 1);
      end
      @(posedge clk);
    end
    @(negedge clk); in_valid = 1'b0;
    done_a = 0; done_bb = 0;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      if (done === 1'b1) done_a++;
      if (done_b === 1'b1) done_bb++;
    end
    checks++;
    if (done_a != 1 || done_bb != 1) begin
      failures++;
      $display("FAIL lockstep_done: got %0d/%0d pulses want 1/1", done_a, done_bb);
    end
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        checks++;
        if (pe_c[i][j] !== W'(i*N + j + 1)) begin
          failures++;
          $display("FAIL lockstep_c[%0d][%0d]: got %0d want %0d", i, j, pe_c[i][j], i*N + j + 1);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_bubble();
    test_zero_len();
    test_reset_mid_pass();
    test_start_while_busy();
    test_back_to_back();
    test_lockstep();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
